// File: rtl/mem_stage_hs.sv
// Memory stage of the LEGv8 pipeline: resolves the branch and runs the req/ack data-memory handshake.
// Optional define MEM_ALIGN_CHECK_EN aborts misaligned accesses in IDLE with a bus error.
module mem_stage_hs #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_M,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] writeData_M,
    input  logic         zero_M,
    input  logic [N-1:0] PCBranch_M,
    input  logic         Branch_M,
    input  logic         MemRead_M,
    input  logic         MemWrite_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_out,
    output logic         stall_M,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata,
    output logic         valid_W,
    output logic [N-1:0] aluResult_W,
    output logic [N-1:0] readData_W,
    output logic         bus_err_W
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          memop;
    logic          misalign;
    logic          lastCycle;

    assign memop = valid_M & (MemRead_M | MemWrite_M);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = memop & (aluResult_M[2:0] != 3'b000);
`else
    assign misalign = 1'b0;
`endif

    // The counter saturates at the abort point, so this also marks the final ACCESS cycle.
    assign lastCycle = (count == CNT_LAST);

    assign stall_M = ((state == IDLE) & memop & ~misalign) |
                     ((state == ACCESS) & ~dm_ack & ~lastCycle);

    assign PCSrc_M      = valid_M & Branch_M & zero_M & (state == IDLE);
    assign PCBranch_out = PCBranch_M;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= '0;
            dm_wdata    <= '0;
            valid_W     <= 1'b0;
            aluResult_W <= '0;
            readData_W  <= '0;
            bus_err_W   <= 1'b0;
        end else begin
            valid_W <= 1'b0;
            case (state)
                IDLE: begin
                    if (misalign) begin
                        valid_W     <= 1'b1;
                        bus_err_W   <= 1'b1;
                        aluResult_W <= aluResult_M;
                    end else if (memop) begin
                        dm_addr  <= aluResult_M;
                        dm_wdata <= writeData_M;
                        dm_we    <= MemWrite_M;
                        dm_req   <= 1'b1;
                        count    <= '0;
                        state    <= ACCESS;
                    end else if (valid_M) begin
                        valid_W     <= 1'b1;
                        bus_err_W   <= 1'b0;
                        aluResult_W <= aluResult_M;
                    end
                end
                ACCESS: begin
                    // An ack on the final cycle still wins over the timeout.
                    if (dm_ack) begin
                        valid_W     <= 1'b1;
                        bus_err_W   <= 1'b0;
                        aluResult_W <= dm_addr;
                        if (!dm_we) begin
                            readData_W <= dm_rdata;
                        end
                        dm_req <= 1'b0;
                        state  <= IDLE;
                    end else if (lastCycle) begin
                        valid_W     <= 1'b1;
                        bus_err_W   <= 1'b1;
                        aluResult_W <= dm_addr;
                        dm_req      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs: directed instructions push expected writeback results,
// a negedge monitor pops and compares whenever valid_W is seen.
module tb_mem_stage_hs;

    logic        clk;
    logic        reset;
    logic        valid_M;
    logic [63:0] aluResult_M;
    logic [63:0] writeData_M;
    logic        zero_M;
    logic [63:0] PCBranch_M;
    logic        Branch_M;
    logic        MemRead_M;
    logic        MemWrite_M;
    logic        PCSrc_M;
    logic [63:0] PCBranch_out;
    logic        stall_M;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_ack;
    logic [63:0] dm_rdata;
    logic        valid_W;
    logic [63:0] aluResult_W;
    logic [63:0] readData_W;
    logic        bus_err_W;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] rd;
        logic        err;
        logic        chkAlu;
        logic        chkRd;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] lastRd;

    mem_stage_hs #(.N(64), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_M      (valid_M),
        .aluResult_M  (aluResult_M),
        .writeData_M  (writeData_M),
        .zero_M       (zero_M),
        .PCBranch_M   (PCBranch_M),
        .Branch_M     (Branch_M),
        .MemRead_M    (MemRead_M),
        .MemWrite_M   (MemWrite_M),
        .PCSrc_M      (PCSrc_M),
        .PCBranch_out (PCBranch_out),
        .stall_M      (stall_M),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_ack       (dm_ack),
        .dm_rdata     (dm_rdata),
        .valid_W      (valid_W),
        .aluResult_W  (aluResult_W),
        .readData_W   (readData_W),
        .bus_err_W    (bus_err_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input logic [63:0] alu, input logic [63:0] rd, input logic err,
                           input logic chkAlu, input logic chkRd);
        exp_t e;
        e.alu = alu; e.rd = rd; e.err = err; e.chkAlu = chkAlu; e.chkRd = chkRd;
        sb.push_back(e);
    endtask

    // Monitor: every writeback pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && valid_W) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid_W: got valid_W=1, expected no result at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("bus_err_W", {63'd0, bus_err_W}, {63'd0, e.err});
                if (e.chkAlu) checkOutput("aluResult_W", aluResult_W, e.alu);
                if (e.chkRd)  checkOutput("readData_W", readData_W, e.rd);
            end
        end
    end

    // Memory instruction issued right after a posedge; memory acks on ACCESS cycle ackAt (< TIMEOUT).
    task automatic applyStimulus(input logic isWrite, input logic isRead, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [63:0] rdata, input int ackAt);
        int stalls;
        stalls = 0;
        valid_M = 1'b1; MemRead_M = isRead; MemWrite_M = isWrite; Branch_M = 1'b0;
        aluResult_M = addr; writeData_M = wdata;
        if (isWrite) begin
            pushExp(addr, lastRd, 1'b0, 1'b1, 1'b1);
        end else begin
            pushExp(addr, rdata, 1'b0, 1'b1, 1'b1);
            lastRd = rdata;
        end
        @(negedge clk);
        if (stall_M) stalls++;
        for (int k = 1; k <= ackAt; k++) begin
            @(posedge clk); #1;
            if (k == ackAt) begin
                dm_ack = 1'b1; dm_rdata = rdata;
            end
            @(negedge clk);
            if (k == 1) begin
                checkOutput("dm_req_access", {63'd0, dm_req}, 64'd1);
                checkOutput("dm_addr", dm_addr, addr);
                checkOutput("dm_we", {63'd0, dm_we}, {63'd0, isWrite});
                if (isWrite) checkOutput("dm_wdata", dm_wdata, wdata);
            end
            if (stall_M) stalls++;
        end
        @(posedge clk); #1;
        dm_ack = 1'b0; valid_M = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0;
        checkOutput("stall_cycles", 64'(stalls), 64'(ackAt));
        @(negedge clk);
        checkOutput("dm_req_after", {63'd0, dm_req}, 64'd0);
        @(posedge clk); #1;
    endtask

    // Non-memory instruction for one cycle, with the branch decision checked combinationally.
    task automatic applyAlu(input logic [63:0] val, input logic br, input logic zero,
                            input logic [63:0] pcb, input logic expPcSrc);
        valid_M = 1'b1; MemRead_M = 1'b0; MemWrite_M = 1'b0;
        Branch_M = br; zero_M = zero; PCBranch_M = pcb; aluResult_M = val;
        pushExp(val, lastRd, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("PCSrc_M", {63'd0, PCSrc_M}, {63'd0, expPcSrc});
        checkOutput("stall_alu", {63'd0, stall_M}, 64'd0);
        if (br) checkOutput("PCBranch_out", PCBranch_out, pcb);
        @(posedge clk); #1;
        valid_M = 1'b0; Branch_M = 1'b0; zero_M = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        int reqCycles;
        logic lastStall;
        reset = 1'b1; valid_M = 1'b0; aluResult_M = '0; writeData_M = '0; zero_M = 1'b0;
        PCBranch_M = '0; Branch_M = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0;
        dm_ack = 1'b0; dm_rdata = '0; lastRd = '0;

        @(negedge clk);
        checkOutput("rst_dm_req", {63'd0, dm_req}, 64'd0);
        checkOutput("rst_valid_W", {63'd0, valid_W}, 64'd0);
        checkOutput("rst_bus_err_W", {63'd0, bus_err_W}, 64'd0);
        checkOutput("rst_aluResult_W", aluResult_W, 64'd0);
        checkOutput("rst_readData_W", readData_W, 64'd0);
        checkOutput("rst_dm_addr", dm_addr, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] LDUR 0x40, ack on ACCESS cycle 3");
        applyStimulus(1'b0, 1'b1, 64'h40, 64'h0, 64'hDEAD_BEEF, 3);
        $display("[TB] STUR 0x80 <- 0x1234, ack on ACCESS cycle 1");
        applyStimulus(1'b1, 1'b0, 64'h80, 64'h1234, 64'hFFFF_0000, 1);
        $display("[TB] MemRead and MemWrite both set acts as a write");
        applyStimulus(1'b1, 1'b1, 64'h88, 64'hA5A5, 64'h1111, 2);

        $display("[TB] CBZ taken and not taken");
        applyAlu(64'h0, 1'b1, 1'b1, 64'h100, 1'b1);
        applyAlu(64'h7, 1'b1, 1'b0, 64'h100, 1'b0);

        $display("[TB] dm_ack in IDLE is ignored");
        dm_ack = 1'b1; dm_rdata = 64'hBAD;
        applyAlu(64'h99, 1'b0, 1'b0, 64'h0, 1'b0);
        dm_ack = 1'b0;
        checkOutput("idle_ack_dm_req", {63'd0, dm_req}, 64'd0);

        $display("[TB] no ack, timeout abort");
        valid_M = 1'b1; MemRead_M = 1'b1; MemWrite_M = 1'b0; aluResult_M = 64'h200;
        pushExp(64'h200, lastRd, 1'b1, 1'b0, 1'b0);
        reqCycles = 0; lastStall = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dm_req) begin
                reqCycles++;
                lastStall = stall_M;
            end else if (reqCycles > 0) begin
                break;
            end
        end
        valid_M = 1'b0; MemRead_M = 1'b0;
        checkOutput("timeout_req_cycles", 64'(reqCycles), 64'd16);
        checkOutput("timeout_stall_release", {63'd0, lastStall}, 64'd0);
        @(posedge clk); #1;

        $display("[TB] LDUR to misaligned address 0x43");
`ifdef MEM_ALIGN_CHECK_EN
        valid_M = 1'b1; MemRead_M = 1'b1; aluResult_M = 64'h43;
        pushExp(64'h43, lastRd, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("align_stall", {63'd0, stall_M}, 64'd0);
        checkOutput("align_dm_req", {63'd0, dm_req}, 64'd0);
        @(posedge clk); #1;
        valid_M = 1'b0; MemRead_M = 1'b0;
        @(negedge clk);
        checkOutput("align_dm_req_next", {63'd0, dm_req}, 64'd0);
        @(posedge clk); #1;
`else
        applyStimulus(1'b0, 1'b1, 64'h43, 64'h0, 64'h77, 1);
`endif

        $display("[TB] reset during ACCESS, then ADD 0x5");
        valid_M = 1'b1; MemRead_M = 1'b1; aluResult_M = 64'h300;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("pre_reset_dm_req", {63'd0, dm_req}, 64'd1);
        #2;
        reset = 1'b1; valid_M = 1'b0; MemRead_M = 1'b0;
        #1;
        checkOutput("async_rst_dm_req", {63'd0, dm_req}, 64'd0);
        checkOutput("async_rst_valid_W", {63'd0, valid_W}, 64'd0);
        checkOutput("async_rst_stall", {63'd0, stall_M}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        lastRd = '0;
        @(negedge clk);
        checkOutput("post_rst_valid_W", {63'd0, valid_W}, 64'd0);
        @(posedge clk); #1;
        applyAlu(64'h5, 1'b0, 1'b0, 64'h0, 1'b0);

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
